// File: rtl/pipe_pkg.sv
// Shared front-end constants: default PC geometry and redirect source indices.
package pipe_pkg;

  // Default PC width, reset vector and sequential step for the fetch stage.
  localparam int PCSIZE_DEFAULT = 16;
  localparam int RESET_PC_DEFAULT = 0;
  localparam int PC_INC_DEFAULT = 4;

  // Redirect source indices; a lower index wins when several fire together.
  localparam int SRC_MISP_TAKEN    = 0;
  localparam int SRC_MISP_NOTTAKEN = 1;
  localparam int SRC_PRED_BRANCH   = 2;
  localparam int SRC_JUMP          = 3;

  // Width of a source index; never narrower than one bit.
  function automatic int src_width(input int nsrc);
    return (nsrc > 1) ? $clog2(nsrc) : 1;
  endfunction

endpackage

// File: rtl/redirect_arbiter.sv
// Fixed-priority selection among redirect requests; index 0 is most urgent.
module redirect_arbiter #(
  parameter int PCSIZE = 16,
  parameter int NSRC = 4,
  parameter int SRCW = 2
) (
  input  logic [NSRC-1:0]        redirect_valid,
  input  logic [NSRC*PCSIZE-1:0] redirect_pc,
  output logic                   any_valid,
  output logic [SRCW-1:0]        sel_idx,
  output logic [PCSIZE-1:0]      sel_pc
);

  // Walk from the lowest priority upward so the lowest set index is left standing.
  always_comb begin
    any_valid = |redirect_valid;
    sel_idx   = '0;
    sel_pc    = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (redirect_valid[i]) begin
        sel_idx = SRCW'(i);
        sel_pc  = redirect_pc[i*PCSIZE +: PCSIZE];
      end
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Next-PC generator: fetch PC register, prioritised redirects, stall/handshake,
// and a multi-cycle kill pulse that squashes wrong-path fetches.
module pc_redirect_unit
  import pipe_pkg::*;
#(
  parameter int                PCSIZE      = PCSIZE_DEFAULT,
  parameter int                NSRC        = 4,
  parameter logic [PCSIZE-1:0] RESET_PC    = PCSIZE'(RESET_PC_DEFAULT),
  parameter int                PC_INC      = PC_INC_DEFAULT,
  parameter int                KILL_CYCLES = 2,
  parameter int                CNTW        = 16,
  localparam int               SRCW        = src_width(NSRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   fetch_ready,
  input  logic [NSRC-1:0]        redirect_valid,
  input  logic [NSRC*PCSIZE-1:0] redirect_pc,
  output logic [PCSIZE-1:0]      pc_out,
  output logic                   pc_valid,
  output logic                   kill,
  output logic [SRCW-1:0]        redirect_src,
  output logic [CNTW-1:0]        redirect_count
);

  // Kill counter must hold the value KILL_CYCLES itself.
  localparam int KCW = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES + 1) : 1;
  localparam logic [KCW-1:0]    KILL_LOAD = KCW'(KILL_CYCLES);
  localparam logic [PCSIZE-1:0] PC_STEP   = PCSIZE'(PC_INC);

  logic [PCSIZE-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              kill_q, kill_d;
  logic [SRCW-1:0]   src_q, src_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [KCW-1:0]    kcnt_q, kcnt_d;

  logic              any_redirect;
  logic [SRCW-1:0]   sel_idx;
  logic [PCSIZE-1:0] sel_pc;
  logic              fetch_accept;

  redirect_arbiter #(
    .PCSIZE(PCSIZE),
    .NSRC  (NSRC),
    .SRCW  (SRCW)
  ) u_arbiter (
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .any_valid     (any_redirect),
    .sel_idx       (sel_idx),
    .sel_pc        (sel_pc)
  );

  assign fetch_accept = valid_q && fetch_ready && !stall;

  // Next-state: a redirect beats sequential advance and ignores stall/handshake;
  // kill only tags older in-flight work, so it never holds the PC back.
  always_comb begin
    pc_d    = pc_q;
    valid_d = 1'b1;
    src_d   = src_q;
    cnt_d   = cnt_q;
    kcnt_d  = kcnt_q;
    if (any_redirect) begin
      pc_d   = sel_pc;
      src_d  = sel_idx;
      cnt_d  = cnt_q + CNTW'(1);
      kcnt_d = KILL_LOAD;
    end else begin
      if (fetch_accept) begin
        pc_d = pc_q + PC_STEP;
      end
      if (kcnt_q != '0) begin
        kcnt_d = kcnt_q - KCW'(1);
      end
    end
    kill_d = (kcnt_d != '0);
  end

  // State registers; reset dominates any redirect presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      kill_q  <= 1'b0;
      src_q   <= '0;
      cnt_q   <= '0;
      kcnt_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      kill_q  <= kill_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      kcnt_q  <= kcnt_d;
    end
  end

  assign pc_out         = pc_q;
  assign pc_valid       = valid_q;
  assign kill           = kill_q;
  assign redirect_src   = src_q;
  assign redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with a behavioural reference model.
module tb_pc_redirect_unit;
  import pipe_pkg::*;

  localparam int PCSIZE = 16;
  localparam int NSRC = 4;
  localparam int KILL_CYCLES = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   stall;
  logic                   fetch_ready;
  logic [NSRC-1:0]        redirect_valid;
  logic [NSRC*PCSIZE-1:0] redirect_pc;
  logic [PCSIZE-1:0]      pc_out;
  logic                   pc_valid;
  logic                   kill;
  logic [1:0]             redirect_src;
  logic [15:0]            redirect_count;

  int checks = 0;
  int errors = 0;

  pc_redirect_unit #(
    .PCSIZE(PCSIZE), .NSRC(NSRC), .RESET_PC(16'h0000), .PC_INC(4),
    .KILL_CYCLES(KILL_CYCLES), .CNTW(16)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_out(pc_out), .pc_valid(pc_valid), .kill(kill),
    .redirect_src(redirect_src), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  // Reference model: the fetch PC, remaining kill cycles and counters as plain values.
  logic [15:0] m_pc;
  bit          m_valid;
  int          m_kill_left;
  int          m_src;
  int          m_count;
  bit          m_init = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 16'h0000; m_valid = 0; m_kill_left = 0; m_src = 0; m_count = 0; m_init = 1;
    end else if (redirect_valid != 0) begin
      int win;
      win = -1;
      for (int i = 0; i < NSRC; i++)
        if (win < 0 && redirect_valid[i]) win = i;
      m_pc = redirect_pc[win*PCSIZE +: PCSIZE];
      m_src = win;
      m_count = (m_count + 1) % 65536;
      m_valid = 1;
      m_kill_left = KILL_CYCLES;
    end else begin
      if (m_valid && fetch_ready && !stall) m_pc = m_pc + 16'd4;
      m_valid = 1;
      if (m_kill_left > 0) m_kill_left = m_kill_left - 1;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every negedge once reset has been seen: DUT outputs against the model.
  always @(negedge clk) begin
    if (m_init) begin
      check("model_pc", int'(pc_out), int'(m_pc));
      check("model_valid", int'(pc_valid), int'(m_valid));
      check("model_kill", int'(kill), (m_kill_left > 0) ? 1 : 0);
      check("model_src", int'(redirect_src), m_src);
      check("model_count", int'(redirect_count), m_count);
    end
  end

  // One clock edge; outputs are then sampled on the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_target(input int idx, input logic [15:0] tgt);
    redirect_pc[idx*PCSIZE +: PCSIZE] = tgt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; stall = 0; fetch_ready = 1; redirect_valid = '0; redirect_pc = '0;
    @(negedge clk);

    // Reset / startup
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_pc", int'(pc_out), 16'h0000);
      check("rst_valid", int'(pc_valid), 0);
      $display("reset cycle %0d: pc=0x%04h valid=%0d", i, pc_out, pc_valid);
    end
    rst = 0;
    tick();
    check("start_valid", int'(pc_valid), 1);
    check("start_pc", int'(pc_out), 16'h0000);
    $display("startup: pc=0x%04h valid=%0d", pc_out, pc_valid);
    tick(); check("seq_pc1", int'(pc_out), 16'h0004);
    tick(); check("seq_pc2", int'(pc_out), 16'h0008);
    tick(); check("seq_pc3", int'(pc_out), 16'h000C);
    tick(); check("seq_pc4", int'(pc_out), 16'h0010);
    $display("sequential fetch: pc=0x%04h", pc_out);

    // Stall and handshake
    stall = 1;
    tick(); check("stall1_pc", int'(pc_out), 16'h0010);
    tick(); check("stall2_pc", int'(pc_out), 16'h0010);
    stall = 0; fetch_ready = 0;
    tick(); check("notready_pc", int'(pc_out), 16'h0010);
    fetch_ready = 1;
    tick(); check("resume_pc", int'(pc_out), 16'h0014);
    $display("stall/handshake: pc=0x%04h", pc_out);

    // Priority: sources 1 and 2 together
    set_target(1, 16'h0200); set_target(2, 16'h0300);
    redirect_valid = 4'b0110;
    tick();
    check("prio_pc", int'(pc_out), 16'h0200);
    check("prio_src", int'(redirect_src), SRC_MISP_NOTTAKEN);
    check("prio_count", int'(redirect_count), 1);
    check("prio_kill0", int'(kill), 1);
    $display("priority redirect: pc=0x%04h src=%0d count=%0d kill=%0d", pc_out, redirect_src, redirect_count, kill);
    redirect_valid = '0;
    tick(); check("prio_kill1", int'(kill), 1); check("prio_adv_pc", int'(pc_out), 16'h0204);
    tick(); check("prio_kill2", int'(kill), 0);

    // Redirect under stall, then kill extension
    stall = 1;
    set_target(3, 16'h0400); redirect_valid = 4'b1000;
    tick();
    check("stallrd_pc", int'(pc_out), 16'h0400);
    check("stallrd_src", int'(redirect_src), SRC_JUMP);
    check("stallrd_kill", int'(kill), 1);
    set_target(0, 16'h0500); redirect_valid = 4'b0001;
    tick();
    check("ext_pc", int'(pc_out), 16'h0500);
    check("ext_src", int'(redirect_src), SRC_MISP_TAKEN);
    check("ext_kill_a", int'(kill), 1);
    check("ext_count", int'(redirect_count), 3);
    redirect_valid = '0;
    tick(); check("ext_kill_b", int'(kill), 1); check("ext_hold_pc", int'(pc_out), 16'h0500);
    tick(); check("ext_kill_end", int'(kill), 0);
    $display("kill extension: pc=0x%04h kill=%0d", pc_out, kill);
    stall = 0;

    // PC wrap
    fetch_ready = 0;
    set_target(0, 16'hFFFC); redirect_valid = 4'b0001;
    tick(); check("wrap_setup_pc", int'(pc_out), 16'hFFFC);
    redirect_valid = '0;
    tick(); tick();
    check("wrap_drained_kill", int'(kill), 0);
    fetch_ready = 1;
    tick();
    check("wrap_pc", int'(pc_out), 16'h0000);
    check("wrap_valid", int'(pc_valid), 1);
    check("wrap_kill", int'(kill), 0);
    $display("wrap: pc=0x%04h valid=%0d kill=%0d", pc_out, pc_valid, kill);

    // Reset in the middle of a kill window, with a redirect pending
    set_target(0, 16'h0700); redirect_valid = 4'b0001;
    tick(); check("pre_rst_kill", int'(kill), 1); check("pre_rst_count", int'(redirect_count), 5);
    rst = 1;
    tick();
    check("midrst_pc", int'(pc_out), 16'h0000);
    check("midrst_kill", int'(kill), 0);
    check("midrst_valid", int'(pc_valid), 0);
    check("midrst_count", int'(redirect_count), 0);
    $display("mid reset: pc=0x%04h kill=%0d valid=%0d count=%0d", pc_out, kill, pc_valid, redirect_count);
    rst = 0; redirect_valid = '0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
Parametrised next-PC generator that replaces the fixed two-flush, two-way PC select.
- Holds the architectural fetch PC in a register.
- Arbitrates NSRC prioritised redirect requests (mispredict-taken, mispredict-not-taken, predicted branch, jump, ...).
- Applies stall and fetch handshake.
- Generates a multi-cycle kill pulse that squashes wrong-path fetches in the front-end.
- Sits between the branch/flush logic in EX and the instruction-fetch stage.

Parameters:
- PCSIZE, 16, PC width in bits.
- NSRC, 4, number of redirect sources; index 0 has highest priority.
- RESET_PC, 0, PC value loaded on reset (PCSIZE bits).
- PC_INC, 4, sequential increment added per accepted fetch.
- KILL_CYCLES, 2, number of cycles kill stays high after a redirect (>=1).
- CNTW, 16, width of the redirect performance counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; freezes sequential advance.
- fetch_ready  in  1  IF stage accepts pc_out this cycle.
- redirect_valid  in  NSRC  per-source redirect request.
- redirect_pc  in  NSRC*PCSIZE  packed targets; source i uses bits [i*PCSIZE +: PCSIZE].
- pc_out  out  PCSIZE  current fetch PC (registered).
- pc_valid  out  1  pc_out is a valid fetch address.
- kill  out  1  squash instructions in flight in IF/ID.
- redirect_src  out  $clog2(NSRC) (min 1)  index of the last accepted redirect.
- redirect_count  out  CNTW  number of accepted redirects, wraps.

Behaviour:
- Reset: while rst is high at a clock edge:
  - pc_out <= RESET_PC
  - pc_valid <= 0
  - kill <= 0
  - redirect_src <= 0
  - redirect_count <= 0
  - kill counter <= 0
  - Reset overrides every other input, including redirects in the same cycle.
- Startup: the first edge with rst low sets pc_valid <= 1; pc_out stays RESET_PC for that edge.
- Fetch acceptance: a fetch is accepted when pc_valid && fetch_ready && !stall.
- Priority per edge, first match wins:
  1. rst.
  2. Any redirect_valid bit set. Take the lowest set index i:
     - pc_out <= redirect_pc[i]
     - redirect_src <= i
     - redirect_count <= redirect_count + 1 (mod 2^CNTW)
     - pc_valid <= 1
     - kill counter <= KILL_CYCLES
     - A redirect is taken even when stall or !fetch_ready.
  3. Fetch accepted: pc_out <= pc_out + PC_INC, truncated to PCSIZE (wraps from max to low values).
  4. Otherwise hold pc_out.
- Kill timing: kill is registered and equals (kill counter != 0).
  - kill goes high on the edge that loads the redirect PC and stays high exactly KILL_CYCLES cycles.
  - The counter decrements once per edge while non-zero and no new redirect arrives.
  - A redirect while the counter is non-zero reloads it to KILL_CYCLES (kill is extended, never shortened).
- Simultaneous requests: only the highest-priority target is used. Lower-priority requests in the same cycle are dropped, not queued.
- Kill does not block PC advance: fetches to the redirect target proceed while kill is high. Kill only marks older in-flight instructions.
- All outputs are registers; there are no combinational input-to-output paths. Redirect latency is 1 cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - PCSIZE default
  - RESET_PC
  - PC_INC
  - redirect source index constants: SRC_MISP_TAKEN=0, SRC_MISP_NOTTAKEN=1, SRC_PRED_BRANCH=2, SRC_JUMP=3
- One sub-module, redirect_arbiter: a combinational parametrised fixed-priority encoder. It outputs any_valid, the selected index and the selected target from redirect_valid/redirect_pc. The PC register, kill counter and perf counter stay in pc_redirect_unit.

Test Plan:
- Reset/startup: rst high 3 cycles, then low, fetch_ready=1, stall=0.
  - During reset: pc_out=0x0000, pc_valid=0.
  - First edge after release: pc_valid=1, pc_out=0x0000.
  - Then pc_out = 0x0004, 0x0008, 0x000C on successive edges.
- Stall/handshake: from pc_out=0x0010, hold stall=1 for 2 cycles, then fetch_ready=0 for 1 cycle.
  - pc_out holds 0x0010 all three cycles and advances to 0x0014 the following cycle.
- Priority: at one edge assert redirect_valid=4'b0110 with targets[1]=0x0200, targets[2]=0x0300.
  - pc_out=0x0200, redirect_src=1, redirect_count increments by 1.
  - kill=1 for exactly 2 cycles.
- Redirect under stall plus kill extension:
  - With stall=1, redirect src 3 to 0x0400: taken next edge.
  - One cycle later, redirect src 0 to 0x0500: pc_out=0x0500, redirect_src=0.
  - kill stays high 3 consecutive cycles in total (reloaded, no gap).
- Wrap: set pc_out via redirect to 0xFFFC, fetch accepted.
  - Next pc_out=0x0000, pc_valid stays 1, no kill.
- Reset mid-operation: assert rst during kill=1 together with redirect_valid=4'b0001.
  - Next edge: pc_out=RESET_PC, kill=0, pc_valid=0, redirect_count=0; the redirect is ignored.
